// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op codes, FSM states and sizing for the multiply/divide sequencer
package muldiv_pkg;
    localparam int MD_WIDTH = 32;
    localparam int MD_ITERS = MD_WIDTH;
    localparam logic [1:0] MD_MUL   = 2'b00;
    localparam logic [1:0] MD_UMULL = 2'b01;
    localparam logic [1:0] MD_SMULL = 2'b10;
    localparam logic [1:0] MD_DIV   = 2'b11;
    typedef enum logic [2:0] {S_IDLE, S_CALC, S_FIX, S_WB_LO, S_WB_HI} state_t;
    function automatic logic is_long(input logic [1:0] op);
        return op == MD_UMULL || op == MD_SMULL;
    endfunction
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add multiply or restoring-divide iteration on P = {hi/rem, lo/quot}
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic [1:0]         i_op,
    input  logic [2*WIDTH-1:0] i_p,
    input  logic [WIDTH-1:0]   i_opnd,
    output logic [2*WIDTH-1:0] o_p
);
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_rem_sh;
    logic [WIDTH:0] w_trial;
    always_comb begin
        w_sum    = {1'b0, i_p[2*WIDTH-1:WIDTH]} + (i_p[0] ? {1'b0, i_opnd} : '0);
        w_rem_sh = i_p[2*WIDTH-1:WIDTH-1];
        // rem < divisor always holds, so bit WIDTH of the difference is the borrow
        w_trial  = w_rem_sh - {1'b0, i_opnd};
        o_p = i_op != MD_DIV ? {w_sum, i_p[WIDTH-1:1]}
            : {w_trial[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0], i_p[WIDTH-2:0], ~w_trial[WIDTH]};
    end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MUL/UMULL/SMULL/DIV sequencer; stalls the core via busy and
// hands back one or two result words through the writeback states.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_ITERS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             res_valid,
    output logic             res_hi,
    output logic [WIDTH-1:0] result,
    output logic             div_zero
);
    localparam int CW = $clog2(WIDTH);
    state_t             r_state;
    logic [1:0]         r_op;
    logic               r_neg;
    logic               r_div_zero;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_opnd;
    logic [2*WIDTH-1:0] r_p;
    logic [2*WIDTH-1:0] w_p_next;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic               w_dz;
    assign w_abs_a = op == MD_SMULL && a[WIDTH-1] ? -a : a;
    assign w_abs_b = op == MD_SMULL && b[WIDTH-1] ? -b : b;
    assign w_dz    = op == MD_DIV && b == '0;
    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_op   (r_op),
        .i_p    (r_p),
        .i_opnd (r_opnd),
        .o_p    (w_p_next)
    );
    // Multiplies keep the multiplier in P's low half; DIV keeps the dividend there
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_op       <= MD_MUL;
            r_neg      <= 1'b0;
            r_div_zero <= 1'b0;
            r_cnt      <= '0;
            r_opnd     <= '0;
            r_p        <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_op       <= op;
                    r_neg      <= op == MD_SMULL && (a[WIDTH-1] ^ b[WIDTH-1]);
                    r_div_zero <= w_dz;
                    r_cnt      <= CW'(WIDTH - 1);
                    r_opnd     <= op == MD_DIV ? b : w_abs_a;
                    r_p        <= {{WIDTH{1'b0}}, w_dz ? {WIDTH{1'b1}} : op == MD_DIV ? a : w_abs_b};
                    r_state    <= w_dz ? S_WB_LO : S_CALC;
                end
                S_CALC: begin
                    r_p     <= w_p_next;
                    r_cnt   <= r_cnt - 1'b1;
                    r_state <= r_cnt == '0 ? S_FIX : S_CALC;
                end
                S_FIX: begin
                    r_p     <= r_op == MD_SMULL && r_neg ? -r_p : r_p;
                    r_state <= S_WB_LO;
                end
                S_WB_LO: r_state <= is_long(r_op) ? S_WB_HI : S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
    assign busy      = r_state != S_IDLE;
    assign res_valid = r_state == S_WB_LO || r_state == S_WB_HI;
    assign res_hi    = r_state == S_WB_HI;
    assign result    = r_state == S_WB_LO ? r_p[WIDTH-1:0] : r_state == S_WB_HI ? r_p[2*WIDTH-1:WIDTH] : '0;
    assign div_zero  = r_div_zero;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed vectors; expected words are queued at issue and checked by a
// monitor whenever res_valid is seen, including the cycle it appears in.
module tb_muldiv_seq;
    import muldiv_pkg::*;
    localparam int W = 32;
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, res_valid, res_hi, div_zero;
    logic [W-1:0] result;
    typedef struct {
        int           cyc;
        logic         hi;
        logic [W-1:0] val;
        logic         dz;
    } exp_t;
    exp_t sb[$];
    exp_t e_m;
    int total = 0;
    int bad = 0;
    int cyc = 0;

    muldiv_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .res_valid (res_valid),
        .res_hi    (res_hi),
        .result    (result),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (res_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected res_valid", 64'(res_valid), 64'd0);
            end else begin
                e_m = sb.pop_front();
                check("wb cycle", 64'(cyc), 64'(e_m.cyc));
                check("res_hi", 64'(res_hi), 64'(e_m.hi));
                check("result", 64'(result), 64'(e_m.val));
                check("div_zero", 64'(div_zero), 64'(e_m.dz));
            end
        end
    end

    task automatic wait_idle(input string nm, input int idle_cyc);
        int n = 0;
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({nm, " busy drop"}, 64'(busy), 64'd0);
        check({nm, " idle cycle"}, 64'(cyc), 64'(idle_cyc));
    endtask

    task automatic run(input string nm, input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] lo, input logic [W-1:0] hi, input logic dz);
        int t;
        logic lng;
        @(negedge clk);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        t = cyc;
        lng = o == MD_UMULL || o == MD_SMULL;
        sb.push_back('{t + (dz ? 1 : 34), 1'b0, lo, dz});
        if (lng) sb.push_back('{t + 35, 1'b1, hi, dz});
        @(negedge clk);
        start = 1'b0;
        op = 2'($urandom);
        a = $urandom;
        b = $urandom;
        check({nm, " busy"}, 64'(busy), 64'd1);
        wait_idle(nm, t + (dz ? 2 : lng ? 36 : 35));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        repeat (3) @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset res_valid", 64'(res_valid), 64'd0);
        check("reset res_hi", 64'(res_hi), 64'd0);
        check("reset result", 64'(result), 64'd0);
        check("reset div_zero", 64'(div_zero), 64'd0);
        reset = 1'b1;
        run("mul 7x6", MD_MUL, 32'd7, 32'd6, 32'd42, 32'd0, 1'b0);
        run("mul trunc", MD_MUL, 32'h12345678, 32'h10, 32'h23456780, 32'd0, 1'b0);
        run("umull max", MD_UMULL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0);
        run("smull -2x3", MD_SMULL, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFA, 32'hFFFFFFFF, 1'b0);
        run("smull 5x-7", MD_SMULL, 32'd5, 32'hFFFFFFF9, 32'hFFFFFFDD, 32'hFFFFFFFF, 1'b0);
        run("smull minneg", MD_SMULL, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 1'b0);
        run("div 100/7", MD_DIV, 32'd100, 32'd7, 32'd14, 32'd0, 1'b0);
        run("div 7/100", MD_DIV, 32'd7, 32'd100, 32'd0, 32'd0, 1'b0);
        run("div max/1", MD_DIV, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0);
        run("div 5/0", MD_DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd0, 1'b1);
        repeat (3) @(negedge clk);
        check("div_zero held", 64'(div_zero), 64'd1);
        // start pulses mid-operation must be ignored
        @(negedge clk);
        start = 1'b1; op = MD_MUL; a = 32'd7; b = 32'd6; t = cyc;
        sb.push_back('{t + 34, 1'b0, 32'd42, 1'b0});
        @(negedge clk);
        start = 1'b0; a = 32'd1234; b = 32'd99;
        check("ign busy", 64'(busy), 64'd1);
        check("ign div_zero cleared", 64'(div_zero), 64'd0);
        repeat (4) @(negedge clk);
        start = 1'b1; op = MD_DIV; a = 32'd9; b = 32'd0;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        start = 1'b1; op = MD_UMULL; a = 32'd3; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        wait_idle("ign", t + 35);
        check("ign queue drained", 64'(sb.size()), 64'd0);
        // reset mid-UMULL aborts without any result
        @(negedge clk);
        start = 1'b1; op = MD_UMULL; a = 32'hFFFFFFFF; b = 32'd2; t = cyc;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort busy", 64'(busy), 64'd0);
        check("abort res_valid", 64'(res_valid), 64'd0);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        check("abort queue", 64'(sb.size()), 64'd0);
        run("post reset umull", MD_UMULL, 32'h00010000, 32'h00030000, 32'h00000000, 32'h00000003, 1'b0);
        repeat (3) @(negedge clk);
        check("final queue", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
